sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (minimum 2).
REQ-002 The block SHALL have port Clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port Rst_l, input, 1 bit, reset that is synchronous and active-low.
REQ-004 The block SHALL have port Serial_In, input, 1 bit, serial data bit, MSB of each word first.
REQ-005 The block SHALL have port Serial_Valid, input, 1 bit, qualifying Serial_In as a valid bit in that cycle.
REQ-006 The block SHALL have port Frame_Abort, input, 1 bit, discarding any partially assembled word.
REQ-007 The block SHALL have port Parallel_Ready, input, 1 bit, signalling that downstream accepts Parallel_Out.
REQ-008 The block SHALL have port Clr_Overrun, input, 1 bit, clearing the sticky Overrun flag.
REQ-009 The block SHALL have port Parallel_Out, output, WIDTH bits, the assembled word.
REQ-010 The block SHALL have port Parallel_Valid, output, 1 bit, asserted while Parallel_Out holds an unconsumed word.
REQ-011 The block SHALL have port Busy, output, 1 bit, asserted while a word is partially assembled.
REQ-012 The block SHALL have port Bit_Count, output, clog2(WIDTH) bits, giving the number of bits collected in the current word.
REQ-013 The block SHALL have port Overrun, output, 1 bit, a sticky flag set when a completed word is dropped.

Function
REQ-014 The assembly FSM SHALL have states IDLE (Bit_Count=0) and SHIFT (Bit_Count 1..WIDTH-1).
REQ-015 Each cycle with Serial_Valid=1 and Frame_Abort=0, the block SHALL shift Serial_In into the LSB of the shift register (left shift) and increment Bit_Count.
REQ-016 A cycle with Serial_Valid=0 SHALL leave the shift register and Bit_Count unchanged, with no timeout.
REQ-017 Transition IDLE->SHIFT SHALL occur on the first accepted bit.
REQ-018 On acceptance of the WIDTH-th bit, Bit_Count SHALL wrap to 0, the FSM SHALL return to IDLE, and the completed word (including that bit) SHALL be offered to the output register in the same edge.
REQ-019 The output register SHALL load and set Parallel_Valid=1 at the edge accepting the WIDTH-th bit (one edge of latency from the final bit), if it is empty or is draining that same cycle.
REQ-020 The output handshake SHALL fire on Parallel_Valid=1 and Parallel_Ready=1; Parallel_Valid SHALL clear on the following edge unless a new word loads at that edge.
REQ-021 While Parallel_Valid=1 and Parallel_Ready=0, Parallel_Out SHALL be held stable.
REQ-022 If a word completes while the output register is full and not draining, the new word SHALL be dropped, the held word kept, and Overrun set to 1.
REQ-023 If a word completes in the same cycle as the handshake, the new word SHALL load, Parallel_Valid SHALL stay 1, and Overrun SHALL be unchanged.
REQ-024 Frame_Abort=1 SHALL clear the shift register and Bit_Count to 0 and force IDLE; it SHALL take priority over Serial_Valid in the same cycle (that bit discarded) and SHALL NOT affect the output register.
REQ-025 Overrun SHALL stay set until Clr_Overrun=1; if a set and a clear coincide, set SHALL win.
REQ-026 Busy SHALL equal (Bit_Count != 0), decoded combinationally from registered state.
REQ-027 Parallel_Ready SHALL be ignored while Parallel_Valid=0.

Reset
REQ-028 While Rst_l=0 at a rising edge, the block SHALL set shift register=0, Bit_Count=0, FSM=IDLE, Parallel_Out=0, Parallel_Valid=0, Overrun=0, Busy=0.
REQ-029 A reset applied mid-word or with a held word SHALL discard all data; there SHALL be no asynchronous effect between edges.

Verification (WIDTH=4)
REQ-030 Scenario: bits 1,0,1,1 on 4 consecutive valid cycles with Ready=1 -> Parallel_Out=4'hB and Parallel_Valid=1 for exactly one cycle after the 4th edge; Busy=1 after bits 1-3.
REQ-031 Scenario: bits 1,1,0,0 with Serial_Valid gaps of 2 idle cycles between bits -> Parallel_Out=4'hC; Bit_Count holds across the gaps.
REQ-032 Scenario: Ready=0, words 4'h5 then 4'hA sent -> Parallel_Out stays 4'h5 and Overrun=1; Clr_Overrun pulse -> Overrun=0.
REQ-033 Scenario: word 4'h3 held and Ready asserted in the cycle the 4th bit of 4'h9 arrives -> 4'h3 accepted, Parallel_Out=4'h9 next, Parallel_Valid continuously 1, Overrun=0.
REQ-034 Scenario: 2 bits sent, then Frame_Abort with Serial_Valid=1, then bits 0,1,1,0 -> Bit_Count=0 after abort, Parallel_Out=4'h6.
REQ-035 Scenario: Rst_l=0 for one edge after 3 bits with word 4'hF held -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial-in/parallel-out bus; master drives serial/control inputs, slave drives word, valid, busy, count and overrun
interface sipo_deserializer_if #(parameter int WIDTH = 4);
  logic                       Serial_In;
  logic                       Serial_Valid;
  logic                       Frame_Abort;
  logic                       Parallel_Ready;
  logic                       Clr_Overrun;
  logic [WIDTH-1:0]           Parallel_Out;
  logic                       Parallel_Valid;
  logic                       Busy;
  logic [$clog2(WIDTH)-1:0]   Bit_Count;
  logic                       Overrun;
  modport master (
    output Serial_In, Serial_Valid, Frame_Abort, Parallel_Ready, Clr_Overrun,
    input  Parallel_Out, Parallel_Valid, Busy, Bit_Count, Overrun
  );
  modport slave (
    input  Serial_In, Serial_Valid, Frame_Abort, Parallel_Ready, Clr_Overrun,
    output Parallel_Out, Parallel_Valid, Busy, Bit_Count, Overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: MSB-first serial-to-parallel assembler with one-word valid/ready output register and sticky overrun; ports Clk, Rst_l (sync active-low), bus (slave)
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input logic                 Clk,
  input logic                 Rst_l,
  sipo_deserializer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [WIDTH-1:0] shift_q, shift_d, out_q, out_d, word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             valid_q, valid_d, ovr_q, ovr_d;
  logic             accept, done, drain, load;
  always_comb begin
    accept  = bus.Serial_Valid & ~bus.Frame_Abort;
    done    = accept & (cnt_q == CW'(WIDTH - 1));
    drain   = valid_q & bus.Parallel_Ready;
    load    = done & (~valid_q | drain);
    word    = {shift_q[WIDTH-2:0], bus.Serial_In};
    shift_d = bus.Frame_Abort ? '0 : accept ? word : shift_q;
    cnt_d   = (bus.Frame_Abort | done) ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    state_d = (cnt_d != '0) ? SHIFT : IDLE;
    out_d   = load ? word : out_q;
    valid_d = load | (valid_q & ~drain);
    ovr_d   = (done & valid_q & ~drain) | (ovr_q & ~bus.Clr_Overrun);
  end
  always_ff @(posedge Clk) begin
    if (!Rst_l) begin
      shift_q <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.Parallel_Out   = out_q;
  assign bus.Parallel_Valid = valid_q;
  assign bus.Busy           = (state_q == SHIFT);
  assign bus.Bit_Count      = cnt_q;
  assign bus.Overrun        = ovr_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: table-driven scenario checks plus a scoreboarded random word stream
module tb_sipo_deserializer;
  typedef struct {
    logic       rst_l, sv, si, ab, rdy, clr;
    logic       pv;
    logic [3:0] po;
    logic [1:0] bc;
    logic       busy, ovr;
  } row_t;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  row_t rows[$];
  logic [3:0] sb[$];
  sipo_deserializer_if #(.WIDTH(4)) bus();
  sipo_deserializer #(.WIDTH(4)) dut (.Clk(clk), .Rst_l(rst_l), .bus(bus));
  always #5 clk = ~clk;
  task automatic add(input logic r, sv, si, ab, rdy, clr, pv, input logic [3:0] po, input logic [1:0] bc, input logic busy, ovr);
    row_t t;
    t.rst_l = r; t.sv = sv; t.si = si; t.ab = ab; t.rdy = rdy; t.clr = clr;
    t.pv = pv; t.po = po; t.bc = bc; t.busy = busy; t.ovr = ovr;
    rows.push_back(t);
  endtask
  task automatic drive(input logic r, sv, si, ab, rdy, clr);
    rst_l = r;
    bus.Serial_Valid = sv;
    bus.Serial_In = si;
    bus.Frame_Abort = ab;
    bus.Parallel_Ready = rdy;
    bus.Clr_Overrun = clr;
  endtask
  task automatic stream_cycle(input logic sv, si, input logic push, input logic [3:0] w);
    logic [3:0] e;
    drive(1'b1, sv, si, 1'b0, 1'b1, 1'b0);
    if (bus.Parallel_Valid && bus.Parallel_Ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL stream_unexpected_word: got %h, required none pending", bus.Parallel_Out);
      end else begin
        e = sb.pop_front();
        if (bus.Parallel_Out !== e) begin
          n_bad++;
          $display("FAIL stream_word: got %h, required %h", bus.Parallel_Out, e);
        end
      end
    end
    if (push) sb.push_back(w);
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [8:0] got, exp;
    logic [3:0] w;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(0,0,0,0,0,0, 0,4'h0,0,0,0);
    add(1,1,1,0,1,0, 0,4'h0,1,1,0);
    add(1,1,0,0,1,0, 0,4'h0,2,1,0);
    add(1,1,1,0,1,0, 0,4'h0,3,1,0);
    add(1,1,1,0,1,0, 1,4'hB,0,0,0);
    add(1,0,0,0,1,0, 0,4'hB,0,0,0);
    add(1,1,1,0,1,0, 0,4'hB,1,1,0);
    add(1,0,0,0,1,0, 0,4'hB,1,1,0);
    add(1,0,0,0,1,0, 0,4'hB,1,1,0);
    add(1,1,1,0,1,0, 0,4'hB,2,1,0);
    add(1,0,0,0,1,0, 0,4'hB,2,1,0);
    add(1,0,0,0,1,0, 0,4'hB,2,1,0);
    add(1,1,0,0,1,0, 0,4'hB,3,1,0);
    add(1,0,0,0,1,0, 0,4'hB,3,1,0);
    add(1,0,0,0,1,0, 0,4'hB,3,1,0);
    add(1,1,0,0,1,0, 1,4'hC,0,0,0);
    add(1,0,0,0,1,0, 0,4'hC,0,0,0);
    add(1,1,0,0,0,0, 0,4'hC,1,1,0);
    add(1,1,1,0,0,0, 0,4'hC,2,1,0);
    add(1,1,0,0,0,0, 0,4'hC,3,1,0);
    add(1,1,1,0,0,0, 1,4'h5,0,0,0);
    add(1,1,1,0,0,0, 1,4'h5,1,1,0);
    add(1,1,0,0,0,0, 1,4'h5,2,1,0);
    add(1,1,1,0,0,0, 1,4'h5,3,1,0);
    add(1,1,0,0,0,0, 1,4'h5,0,0,1);
    add(1,0,0,0,0,0, 1,4'h5,0,0,1);
    add(1,0,0,0,0,1, 1,4'h5,0,0,0);
    add(1,0,0,0,1,0, 0,4'h5,0,0,0);
    add(1,1,0,0,0,0, 0,4'h5,1,1,0);
    add(1,1,0,0,0,0, 0,4'h5,2,1,0);
    add(1,1,1,0,0,0, 0,4'h5,3,1,0);
    add(1,1,1,0,0,0, 1,4'h3,0,0,0);
    add(1,1,1,0,0,0, 1,4'h3,1,1,0);
    add(1,1,0,0,0,0, 1,4'h3,2,1,0);
    add(1,1,0,0,0,0, 1,4'h3,3,1,0);
    add(1,1,1,0,1,0, 1,4'h9,0,0,0);
    add(1,0,0,0,0,0, 1,4'h9,0,0,0);
    add(1,1,1,0,0,0, 1,4'h9,1,1,0);
    add(1,1,1,0,0,0, 1,4'h9,2,1,0);
    add(1,1,1,0,0,0, 1,4'h9,3,1,0);
    add(1,1,1,0,0,1, 1,4'h9,0,0,1);
    add(1,0,0,0,0,1, 1,4'h9,0,0,0);
    add(1,0,0,0,1,0, 0,4'h9,0,0,0);
    add(1,1,1,0,1,0, 0,4'h9,1,1,0);
    add(1,1,0,0,1,0, 0,4'h9,2,1,0);
    add(1,1,1,1,1,0, 0,4'h9,0,0,0);
    add(1,1,0,0,1,0, 0,4'h9,1,1,0);
    add(1,1,1,0,1,0, 0,4'h9,2,1,0);
    add(1,1,1,0,1,0, 0,4'h9,3,1,0);
    add(1,1,0,0,0,0, 1,4'h6,0,0,0);
    add(1,0,0,1,0,0, 1,4'h6,0,0,0);
    add(1,0,0,0,1,0, 0,4'h6,0,0,0);
    add(1,1,1,0,0,0, 0,4'h6,1,1,0);
    add(1,1,1,0,0,0, 0,4'h6,2,1,0);
    add(1,1,1,0,0,0, 0,4'h6,3,1,0);
    add(1,1,1,0,0,0, 1,4'hF,0,0,0);
    add(1,1,1,0,0,0, 1,4'hF,1,1,0);
    add(1,1,0,0,0,0, 1,4'hF,2,1,0);
    add(1,1,1,0,0,0, 1,4'hF,3,1,0);
    add(0,1,1,0,0,0, 0,4'h0,0,0,0);
    add(1,0,0,0,1,0, 0,4'h0,0,0,0);
    @(negedge clk);
    foreach (rows[i]) begin
      drive(rows[i].rst_l, rows[i].sv, rows[i].si, rows[i].ab, rows[i].rdy, rows[i].clr);
      @(negedge clk);
      got = {bus.Parallel_Valid, bus.Parallel_Out, bus.Bit_Count, bus.Busy, bus.Overrun};
      exp = {rows[i].pv, rows[i].po, rows[i].bc, rows[i].busy, rows[i].ovr};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL row%0d: got pv=%b po=%h bc=%0d busy=%b ovr=%b, required pv=%b po=%h bc=%0d busy=%b ovr=%b",
                 i, got[8], got[7:4], got[3:2], got[1], got[0], exp[8], exp[7:4], exp[3:2], exp[1], exp[0]);
      end
    end
    for (int k = 0; k < 20; k++) begin
      w = 4'($urandom_range(0, 15));
      for (int b = 3; b >= 0; b--) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) stream_cycle(1'b0, 1'b0, 1'b0, w);
        stream_cycle(1'b1, w[b], b == 0, w);
      end
    end
    for (int k = 0; k < 3; k++) stream_cycle(1'b0, 1'b0, 1'b0, 4'h0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL stream_drain: got %0d words pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
